// File: rtl/alu_seq.sv
// Multi-cycle execute stage: latches operands on start, iterates shifts/multiply, emits one writeback beat.
// Optional macro ALU_SEQ_MUL_EN builds the shift-add multiplier for op 111; otherwise op 111 is an illegal-op NOP.
module alu_seq #(
    parameter int reg_width = 8,
    parameter int num_regs  = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [2:0]                  op,
    input  logic [reg_width-1:0]        rs_in,
    input  logic [reg_width-1:0]        rt_in,
    input  logic [$clog2(num_regs)-1:0] rd_addr_in,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(num_regs)-1:0] rd_addr,
    output logic [reg_width-1:0]        rd_in,
    output logic                        reg_write,
    output logic [reg_width-1:0]        car_in,
    output logic                        car_write
);
    localparam int aw = $clog2(num_regs);
    localparam int cw = $clog2(reg_width + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [reg_width-1:0] a_q, a_d, b_q, b_d;
    logic [aw-1:0]        addr_q, addr_d;
    logic [cw-1:0]        cnt_q, cnt_d;
    logic [reg_width-1:0] rd_in_q, rd_in_d, car_in_q, car_in_d;
    logic [aw-1:0]        rd_addr_q, rd_addr_d;
    logic                 done_q, done_d, reg_write_q, reg_write_d, car_write_q, car_write_d;
    logic [reg_width-1:0] res, car;
    logic                 res_ok, car_ok;
    logic [reg_width:0]   add_sum;
    logic                 shift_en;

    assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
    assign shift_en = (b_q[2:0] != 3'd0);

`ifdef ALU_SEQ_MUL_EN
    // Product accumulates as {acc_q, a_q}; a_q doubles as the multiplier shift register.
    logic [reg_width-1:0] acc_q, acc_d;
    logic [reg_width:0]   mul_sum;
    assign mul_sum = a_q[0] ? ({1'b0, acc_q} + {1'b0, b_q}) : {1'b0, acc_q};
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        rd_in_d     = rd_in_q;
        car_in_d    = car_in_q;
        rd_addr_d   = rd_addr_q;
        done_d      = 1'b0;
        reg_write_d = 1'b0;
        car_write_d = 1'b0;
        res         = rd_in_q;
        car         = car_in_q;
        res_ok      = 1'b1;
        car_ok      = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        acc_d       = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d   = op;
                    a_d    = rs_in;
                    b_d    = rt_in;
                    addr_d = rd_addr_in;
                    cnt_d  = '0;
                    if ((op == OP_SHL || op == OP_SHR) && rt_in[2:0] != 3'd0)
                        cnt_d = cw'(rt_in[2:0] - 3'd1);
`ifdef ALU_SEQ_MUL_EN
                    if (op == 3'd7) begin
                        cnt_d = cw'(reg_width - 1);
                        acc_d = '0;
                    end
`endif
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        res    = add_sum[reg_width-1:0];
                        car    = {{(reg_width-1){1'b0}}, add_sum[reg_width]};
                        car_ok = 1'b1;
                    end
                    OP_SUB: begin
                        res    = a_q - b_q;
                        car    = {{(reg_width-1){1'b0}}, (a_q < b_q)};
                        car_ok = 1'b1;
                    end
                    OP_AND: res = a_q & b_q;
                    OP_OR:  res = a_q | b_q;
                    OP_XOR: res = a_q ^ b_q;
                    OP_SHL: begin
                        if (shift_en) a_d = {a_q[reg_width-2:0], 1'b0};
                        res = a_d;
                    end
                    OP_SHR: begin
                        if (shift_en) a_d = {1'b0, a_q[reg_width-1:1]};
                        res = a_d;
                    end
                    default: begin
`ifdef ALU_SEQ_MUL_EN
                        acc_d  = mul_sum[reg_width:1];
                        a_d    = {mul_sum[0], a_q[reg_width-1:1]};
                        res    = a_d;
                        car    = acc_d;
                        car_ok = 1'b1;
`else
                        res_ok = 1'b0;
`endif
                    end
                endcase
                if (cnt_q == '0) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    rd_addr_d = addr_q;
                    if (res_ok) begin
                        rd_in_d     = res;
                        reg_write_d = (addr_q != '0);
                    end
                    if (car_ok) begin
                        car_in_d    = car;
                        car_write_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - cw'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            rd_in_q     <= '0;
            car_in_q    <= '0;
            rd_addr_q   <= '0;
            done_q      <= 1'b0;
            reg_write_q <= 1'b0;
            car_write_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            rd_in_q     <= rd_in_d;
            car_in_q    <= car_in_d;
            rd_addr_q   <= rd_addr_d;
            done_q      <= done_d;
            reg_write_q <= reg_write_d;
            car_write_q <= car_write_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign rd_addr   = rd_addr_q;
    assign rd_in     = rd_in_q;
    assign reg_write = reg_write_q;
    assign car_in    = car_in_q;
    assign car_write = car_write_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: transaction-level reference model compared every cycle, plus literal directed cases.
module tb_alu_seq;
    localparam int W  = 8;
    localparam int NR = 12;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  rs_in = '0;
    logic [W-1:0]  rt_in = '0;
    logic [AW-1:0] rd_addr_in = '0;
    logic          busy, done, reg_write, car_write;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_in, car_in;

    int checks = 0;
    int errors = 0;

    alu_seq #(.reg_width(W), .num_regs(NR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_in(rs_in), .rt_in(rt_in), .rd_addr_in(rd_addr_in),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_in(rd_in),
        .reg_write(reg_write), .car_in(car_in), .car_write(car_write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    // Reference: counts edges remaining to the done cycle, results from plain arithmetic.
    int  m_cnt = 0;
    bit  m_done = 0;
    int  p_op, p_a, p_b, p_rd;
    int  e_rd = 0, e_car = 0, e_addr = 0;
    bit  e_done = 0, e_rw = 0, e_cw = 0;

    function automatic int latency(input int o, input int b);
        int n;
        n = b % 8;
        if (o == 5 || o == 6) return 1 + ((n == 0) ? 1 : n);
        if (o == 7 && MUL_ON) return 1 + W;
        return 2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_done = 0;
            e_rd = 0; e_car = 0; e_addr = 0;
            e_done = 0; e_rw = 0; e_cw = 0;
        end else begin
            e_done = 0; e_rw = 0; e_cw = 0;
            if (m_done) begin
                m_done = 0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    int n;
                    bit legal;
                    m_done = 1;
                    e_done = 1;
                    e_addr = p_rd;
                    legal  = 1;
                    n      = p_b % 8;
                    case (p_op)
                        0: begin e_rd = (p_a + p_b) % 256; e_car = (p_a + p_b) / 256; e_cw = 1; end
                        1: begin e_rd = (p_a - p_b + 256) % 256; e_car = (p_a < p_b) ? 1 : 0; e_cw = 1; end
                        2: e_rd = p_a & p_b;
                        3: e_rd = p_a | p_b;
                        4: e_rd = p_a ^ p_b;
                        5: e_rd = (p_a << n) % 256;
                        6: e_rd = p_a >> n;
                        default: begin
                            if (MUL_ON) begin
                                e_rd = (p_a * p_b) % 256; e_car = (p_a * p_b) / 256; e_cw = 1;
                            end else begin
                                legal = 0;
                            end
                        end
                    endcase
                    e_rw = legal && (p_rd != 0);
                end
            end else if (start) begin
                p_op = int'(op); p_a = int'(rs_in); p_b = int'(rt_in); p_rd = int'(rd_addr_in);
                m_cnt = latency(p_op, p_b) - 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_cnt > 0 || m_done));
        chk("done", int'(done), int'(e_done));
        chk("reg_write", int'(reg_write), int'(e_rw));
        chk("car_write", int'(car_write), int'(e_cw));
        chk("rd_in", int'(rd_in), e_rd);
        chk("car_in", int'(car_in), e_car);
        chk("rd_addr", int'(rd_addr), e_addr);
    end

    task automatic run_op(input string tag, input int o, input int a, input int b, input int rd,
                          input int x_lat, input int x_rd, input int x_car, input int x_rw, input int x_cw);
        int k;
        @(negedge clk);
        start = 1'b1; op = 3'(o); rs_in = W'(a); rt_in = W'(b); rd_addr_in = AW'(rd);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, k, x_lat);
        chk({tag, " rd_in"}, int'(rd_in), x_rd);
        chk({tag, " car_in"}, int'(car_in), x_car);
        chk({tag, " reg_write"}, int'(reg_write), x_rw);
        chk({tag, " car_write"}, int'(car_write), x_cw);
        chk({tag, " rd_addr"}, int'(rd_addr), rd);
        @(negedge clk);
        chk({tag, " idle after"}, int'(busy || done), 0);
    endtask

    initial begin
        int ndone, last;
        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset outputs", int'({done, reg_write, car_write, rd_in, car_in, rd_addr}), 0);
        rst_n = 1'b1;

        run_op("ADD", 0, 'hF0, 'h20, 5, 2, 'h10, 'h01, 1, 1);
        run_op("SUB", 1, 'h03, 'h05, 0, 2, 'hFE, 'h01, 0, 1);
        run_op("SHL", 5, 'h81, 'h03, 7, 4, 'h08, 'h01, 1, 0);
        run_op("SHR", 6, 'h81, 'h00, 7, 2, 'h81, 'h01, 1, 0);
        if (MUL_ON) run_op("MUL", 7, 'hFF, 'hFF, 2, 9, 'h01, 'hFE, 1, 1);
        else        run_op("MUL off", 7, 'hFF, 'hFF, 2, 2, 'h81, 'h01, 0, 0);

        // Abort a long op in its 4th EXEC cycle.
        @(negedge clk);
        start = 1'b1; rs_in = 8'h10; rt_in = MUL_ON ? 8'h10 : 8'h07; rd_addr_in = 4'd3;
        op = MUL_ON ? 3'd7 : 3'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid-op busy before reset", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort strobes", int'({done, reg_write, car_write}), 0);
        chk("abort outputs", int'({rd_in, car_in, rd_addr}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Start held high: XOR stream accepted every third cycle.
        start = 1'b1; op = 3'd4; rd_addr_in = 4'd6;
        ndone = 0; last = -1;
        for (int c = 1; c <= 30; c++) begin
            rs_in = W'($urandom); rt_in = W'($urandom);
            @(negedge clk);
            if (done) begin
                if (last >= 0) chk("stream gap", c - last, 3);
                last = c;
                ndone++;
            end
        end
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("stream done count", ndone, 10);

        // Random traffic, including starts while busy.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            op = 3'($urandom_range(0, 7));
            rs_in = W'($urandom);
            rt_in = W'($urandom);
            rd_addr_in = AW'($urandom_range(0, NR - 1));
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
